// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, single-outstanding imem request, output FIFO, redirect flush
// Optional FETCH_PERF_CNT_EN adds the saturating perf_fetched pop counter.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_raw,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {RUN, WAIT, DROP} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   mem_raw_q [DEPTH];
  logic [31:0]   mem_pc_q  [DEPTH];

  logic fire;
  logic push;
  logic pop;

  // Only RUN can issue, so the outstanding slot term of the space check is always zero here.
  assign imem_req_valid = ~rst & (state_q == RUN) & (count_q < DEPTH_C) & ~redirect_valid;
  assign imem_req_addr  = pc_q;
  assign instr_valid    = (count_q != '0);
  assign instr_raw      = instr_valid ? mem_raw_q[rd_ptr_q] : 32'h0;
  assign instr_pc       = instr_valid ? mem_pc_q[rd_ptr_q]  : 32'h0;

  assign fire = imem_req_valid & imem_req_ready;
  assign pop  = instr_valid & instr_ready;
  assign push = (state_q == WAIT) & imem_resp_valid & ~redirect_valid;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc & 32'hFFFF_FFFC;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      // A response landing in the redirect cycle retires the outstanding slot.
      if (state_q != RUN && !imem_resp_valid) state_d = DROP;
      else                                    state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (fire) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = WAIT;
          end
        end
        WAIT:    if (imem_resp_valid) state_d = RUN;
        DROP:    if (imem_resp_valid) state_d = RUN;
        default: state_d = RUN;
      endcase
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      req_pc_q <= 32'h0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_raw_q[wr_ptr_q] <= imem_resp_data;
      mem_pc_q[wr_ptr_q]  <= req_pc_q;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (pop && perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= 32'h0;
    else     perf_q <= perf_d;
  end

  assign perf_fetched = perf_q;
`endif

  resp_only_when_outstanding: assert property (
    @(posedge clk) disable iff (rst) !(imem_resp_valid && state_q == RUN));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed check of fetch_unit against a queue-based reference model
module tb_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_raw;
  logic [31:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] s_perf;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_raw(instr_raw), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched)
`endif
  );

  typedef struct {
    logic [31:0] raw;
    logic [31:0] pc;
  } ent_t;

  int checks = 0;
  int errors = 0;

  ent_t        m_fifo[$];
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  bit          m_out;
  bit          m_stale;
  logic [31:0] m_pops;

  bit          pend;
  int          cnt;
  int          lat;

  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];
  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_ivalid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    imem_resp_valid = 1'b0;
    imem_req_ready = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    pend = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr_raw", instr_raw, 0);
    chk("rst_instr_pc", instr_pc, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf", perf_fetched, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_fifo.delete();
    m_pc = 32'h0;
    m_req_pc = 32'h0;
    m_out = 1'b0;
    m_stale = 1'b0;
    m_pops = 32'h0;
    acc_log.delete();
    pop_log.delete();
  endtask

  // One clock: memory responds, inputs applied, outputs compared at negedge, model advanced.
  task automatic cycle(input bit rdv, input bit irdy, input bit redir, input logic [31:0] rpc);
    bit   exp_req;
    bit   pop;
    bit   acc;
    ent_t e;
    imem_resp_valid = 1'b0;
    imem_resp_data = $urandom;
    if (pend) begin
      cnt--;
      if (cnt <= 0) begin
        imem_resp_valid = 1'b1;
        pend = 1'b0;
      end
    end
    imem_req_ready = rdv;
    instr_ready = irdy;
    redirect_valid = redir;
    redirect_pc = rpc;
    @(negedge clk);
    exp_req = !m_out && (m_fifo.size() < DEPTH) && !redir;
    chk("req_valid", imem_req_valid, exp_req);
    if (exp_req) chk("req_addr", imem_req_addr, m_pc);
    chk("instr_valid", instr_valid, m_fifo.size() != 0);
    chk("instr_raw", instr_raw, (m_fifo.size() != 0) ? m_fifo[0].raw : 32'h0);
    chk("instr_pc", instr_pc, (m_fifo.size() != 0) ? m_fifo[0].pc : 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, m_pops);
    s_perf = perf_fetched;
`endif
    s_req_valid = imem_req_valid;
    s_req_addr = imem_req_addr;
    s_ivalid = instr_valid;
    if (imem_req_valid && imem_req_ready) begin
      pend = 1'b1;
      cnt = (lat != 0) ? lat : int'($urandom_range(1, 4));
      acc_log.push_back(imem_req_addr);
    end
    if (instr_valid && instr_ready) pop_log.push_back(instr_pc);

    pop = (m_fifo.size() != 0) && irdy;
    acc = exp_req && rdv;
    if (pop) m_pops++;
    if (redir) begin
      m_fifo.delete();
      m_pc = rpc & ~32'h3;
      if (m_out) begin
        if (imem_resp_valid) begin
          m_out = 1'b0;
          m_stale = 1'b0;
        end else begin
          m_stale = 1'b1;
        end
      end
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (imem_resp_valid && m_out) begin
        if (!m_stale) begin
          e.raw = imem_resp_data;
          e.pc = m_req_pc;
          m_fifo.push_back(e);
        end
        m_out = 1'b0;
        m_stale = 1'b0;
      end
      if (acc) begin
        m_req_pc = m_pc;
        m_pc = m_pc + 32'd4;
        m_out = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Sequential fetch, 1-cycle memory, decoder always ready.
    do_reset();
    lat = 1;
    repeat (8) cycle(1, 1, 0, 32'h0);
    chk("t1_acc0", q_at(acc_log, 0), 32'h0);
    chk("t1_acc1", q_at(acc_log, 1), 32'h4);
    chk("t1_acc2", q_at(acc_log, 2), 32'h8);
    chk("t1_pop0", q_at(pop_log, 0), 32'h0);
    chk("t1_pop1", q_at(pop_log, 1), 32'h4);
    chk("t1_pop2", q_at(pop_log, 2), 32'h8);

    // Decoder stalled: exactly DEPTH words buffered, no third request.
    do_reset();
    lat = 1;
    repeat (10) cycle(1, 0, 0, 32'h0);
    chk("t2_acc_count", acc_log.size(), 2);
    chk("t2_held_valid", s_ivalid, 1);
    repeat (6) cycle(1, 1, 0, 32'h0);
    chk("t2_resume_addr", q_at(acc_log, 2), 32'h8);
    chk("t2_pop0", q_at(pop_log, 0), 32'h0);
    chk("t2_pop1", q_at(pop_log, 1), 32'h4);

    // Redirect to 0x103 while a 3-cycle request is outstanding.
    do_reset();
    lat = 3;
    cycle(1, 1, 0, 32'h0);
    cycle(1, 1, 1, 32'h103);
    repeat (10) cycle(1, 1, 0, 32'h0);
    chk("t3_next_addr", q_at(acc_log, 1), 32'h100);
    chk("t3_first_pc", q_at(pop_log, 0), 32'h100);

    // Redirect in the same cycle as the response.
    do_reset();
    lat = 2;
    cycle(1, 1, 0, 32'h0);
    cycle(1, 1, 0, 32'h0);
    cycle(1, 1, 1, 32'h2003);
    cycle(1, 1, 0, 32'h0);
    chk("t4_valid_after", s_ivalid, 0);
    chk("t4_req_valid", s_req_valid, 1);
    chk("t4_req_addr", s_req_addr, 32'h2000);

    // Memory not ready for 5 cycles: request held stable.
    do_reset();
    lat = 1;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 0, 32'h0);
      chk("t5_hold_valid", s_req_valid, 1);
      chk("t5_hold_addr", s_req_addr, 32'h0);
    end
    cycle(1, 1, 0, 32'h0);
    cycle(1, 1, 0, 32'h0);
    cycle(1, 1, 0, 32'h0);
    chk("t5_next_addr", s_req_addr, 32'h4);

`ifdef FETCH_PERF_CNT_EN
    // Ten pops with a redirect flush in the middle.
    do_reset();
    lat = 1;
    for (int i = 0; i < 200 && pop_log.size() < 10; i++)
      cycle(1, 1, (i == 6), 32'h40);
    cycle(1, 0, 0, 32'h0);
    chk("perf_ten", s_perf, 32'd10);
`endif

    // Randomized traffic with occasional redirects and resets.
    do_reset();
    lat = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
            $urandom_range(0, 29) == 0, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
